// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stall requests and exception in, stall vector/flush/statistics out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             mem_busy;
  logic             excp_valid;
  logic [31:0]      excp_pc;
  logic             cnt_clr;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             excp_ack;
  logic [CNT_W-1:0] stall_cycles;
  logic             stall_timeout;
  logic [1:0]       ctrl_state;

  modport master (
    output stallreq_id, stallreq_ex, mem_busy, excp_valid, excp_pc, cnt_clr,
    input  stall, flush, new_pc, excp_ack, stall_cycles, stall_timeout, ctrl_state
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mem_busy, excp_valid, excp_pc, cnt_clr,
    output stall, flush, new_pc, excp_ack, stall_cycles, stall_timeout, ctrl_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: stall vector, exception flush arbitration, stall statistics/watchdog.
// stall/flush/new_pc/excp_ack act in the same cycle; state and counters update on the next edge.
module pipe_ctrl #(
  parameter int MAX_STALL = 255,
  parameter int RUN_W     = 8,
  parameter int CNT_W     = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_HOLD      = 2'd1,
    S_EXCP_WAIT = 2'd2,
    S_RECOVER   = 2'd3
  } state_t;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [RUN_W-1:0] r_stall_run;
  logic             r_stall_timeout;

  logic [5:0]       w_req_stall;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic             w_any_req;
  logic             w_stalled;
  logic [RUN_W-1:0] w_run_inc;

  assign w_any_req = bus.stallreq_id | bus.stallreq_ex | bus.mem_busy;

  always_comb begin
    w_req_stall = STALL_NONE;
    if (bus.mem_busy)         w_req_stall = STALL_MEM;
    else if (bus.stallreq_ex) w_req_stall = STALL_EX;
    else if (bus.stallreq_id) w_req_stall = STALL_ID;
  end

  always_comb begin
    w_stall     = w_req_stall;
    w_flush     = 1'b0;
    w_state_nxt = w_any_req ? S_HOLD : S_RUN;
    case (r_state)
      S_RUN, S_HOLD: begin
        if (bus.excp_valid) begin
          // An outstanding memory access must finish before the flush can kill it.
          if (bus.mem_busy) begin
            w_stall     = STALL_MEM;
            w_state_nxt = S_EXCP_WAIT;
          end else begin
            w_stall     = STALL_NONE;
            w_flush     = 1'b1;
            w_state_nxt = S_RECOVER;
          end
        end
      end
      S_EXCP_WAIT: begin
        if (!bus.excp_valid) begin
          w_state_nxt = S_RUN;
        end else if (bus.mem_busy) begin
          w_stall     = STALL_MEM;
          w_state_nxt = S_EXCP_WAIT;
        end else begin
          w_stall     = STALL_NONE;
          w_flush     = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // excp_valid ignored here so a source still holding it cannot fire twice.
        w_stall = STALL_NONE;
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (rst) begin
      w_stall = STALL_NONE;
      w_flush = 1'b0;
    end
  end

  assign w_stalled = |w_stall;
  assign w_run_inc = (&r_stall_run) ? r_stall_run : r_stall_run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_RUN;
      r_stall_cycles  <= '0;
      r_stall_run     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.cnt_clr) begin
        r_stall_cycles  <= '0;
        r_stall_run     <= '0;
        r_stall_timeout <= 1'b0;
      end else begin
        if (w_stalled && !(&r_stall_cycles))
          r_stall_cycles <= r_stall_cycles + 1'b1;
        if (w_stalled && !w_flush) begin
          r_stall_run <= w_run_inc;
          if (w_run_inc == RUN_W'(MAX_STALL))
            r_stall_timeout <= 1'b1;
        end else begin
          r_stall_run <= '0;
        end
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.excp_ack      = w_flush;
  assign bus.new_pc        = w_flush ? bus.excp_pc : 32'h0;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.stall_timeout = r_stall_timeout;
  assign bus.ctrl_state    = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception arbitration, counters, watchdog, reset.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .MAX_STALL(4),
    .RUN_W    (8),
    .CNT_W    (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Inputs change 1ns after the edge; sampling happens 3ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.excp_valid  = 1'b0;
    bus.excp_pc     = 32'h0;
    bus.cnt_clr     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_state", 64'(bus.ctrl_state), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'h00);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_new_pc", 64'(bus.new_pc), 64'h0);
    chk("rst_ack", 64'(bus.excp_ack), 64'd0);
    chk("rst_cycles", 64'(bus.stall_cycles), 64'd0);
    chk("rst_timeout", 64'(bus.stall_timeout), 64'd0);

    // load-use hold for two cycles
    tick();
    bus.stallreq_id = 1'b1;
    settle();
    chk("id_c1_stall", 64'(bus.stall), 64'h07);
    chk("id_c1_state", 64'(bus.ctrl_state), 64'd0);
    tick();
    settle();
    chk("id_c2_stall", 64'(bus.stall), 64'h07);
    chk("id_c2_state", 64'(bus.ctrl_state), 64'd1);
    chk("id_c2_cycles", 64'(bus.stall_cycles), 64'd1);
    tick();
    bus.stallreq_id = 1'b0;
    settle();
    chk("id_rel_stall", 64'(bus.stall), 64'h00);
    chk("id_rel_state", 64'(bus.ctrl_state), 64'd1);
    chk("id_rel_cycles", 64'(bus.stall_cycles), 64'd2);
    tick();
    settle();
    chk("id_idle_state", 64'(bus.ctrl_state), 64'd0);

    // priority mem > ex > id
    tick();
    bus.stallreq_id = 1'b1;
    bus.stallreq_ex = 1'b1;
    bus.mem_busy    = 1'b1;
    settle();
    chk("prio_mem", 64'(bus.stall), 64'h1F);
    tick();
    bus.mem_busy = 1'b0;
    settle();
    chk("prio_ex", 64'(bus.stall), 64'h0F);
    tick();
    bus.stallreq_ex = 1'b0;
    settle();
    chk("prio_id", 64'(bus.stall), 64'h07);
    tick();
    bus.stallreq_id = 1'b0;
    settle();
    chk("prio_none", 64'(bus.stall), 64'h00);
    chk("prio_cycles", 64'(bus.stall_cycles), 64'd5);
    chk("prio_timeout", 64'(bus.stall_timeout), 64'd0);

    // exception with no memory access overrides an EX stall
    tick();
    tick();
    bus.excp_valid  = 1'b1;
    bus.excp_pc     = 32'hBFC00380;
    bus.stallreq_ex = 1'b1;
    settle();
    chk("ex0_flush", 64'(bus.flush), 64'd1);
    chk("ex0_ack", 64'(bus.excp_ack), 64'd1);
    chk("ex0_new_pc", 64'(bus.new_pc), 64'hBFC00380);
    chk("ex0_stall", 64'(bus.stall), 64'h00);
    tick();
    settle();
    chk("ex0_rec_state", 64'(bus.ctrl_state), 64'd3);
    chk("ex0_rec_ack", 64'(bus.excp_ack), 64'd0);
    chk("ex0_rec_flush", 64'(bus.flush), 64'd0);
    chk("ex0_rec_stall", 64'(bus.stall), 64'h00);
    chk("ex0_rec_cycles", 64'(bus.stall_cycles), 64'd5);
    tick();
    bus.excp_valid  = 1'b0;
    bus.stallreq_ex = 1'b0;
    settle();
    chk("ex0_after_state", 64'(bus.ctrl_state), 64'd1);
    tick();
    settle();
    chk("ex0_idle_state", 64'(bus.ctrl_state), 64'd0);

    // exception waits three cycles behind a busy memory access
    tick();
    bus.excp_valid = 1'b1;
    bus.excp_pc    = 32'h80000180;
    bus.mem_busy   = 1'b1;
    settle();
    chk("exw_c1_stall", 64'(bus.stall), 64'h1F);
    chk("exw_c1_flush", 64'(bus.flush), 64'd0);
    for (int k = 2; k <= 3; k++) begin
      tick();
      settle();
      chk("exw_wait_state", 64'(bus.ctrl_state), 64'd2);
      chk("exw_wait_stall", 64'(bus.stall), 64'h1F);
      chk("exw_wait_ack", 64'(bus.excp_ack), 64'd0);
    end
    tick();
    bus.mem_busy = 1'b0;
    settle();
    chk("exw_fire_flush", 64'(bus.flush), 64'd1);
    chk("exw_fire_ack", 64'(bus.excp_ack), 64'd1);
    chk("exw_fire_pc", 64'(bus.new_pc), 64'h80000180);
    chk("exw_fire_stall", 64'(bus.stall), 64'h00);
    tick();
    bus.excp_valid = 1'b0;
    settle();
    chk("exw_rec_state", 64'(bus.ctrl_state), 64'd3);
    chk("exw_cycles", 64'(bus.stall_cycles), 64'd8);
    tick();

    // watchdog: six EX stall cycles against a limit of four
    tick();
    bus.stallreq_ex = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("wd_stall", 64'(bus.stall), 64'h0F);
      chk("wd_timeout", 64'(bus.stall_timeout), (k >= 5) ? 64'd1 : 64'd0);
      tick();
    end
    bus.stallreq_ex = 1'b0;
    settle();
    chk("wd_sticky", 64'(bus.stall_timeout), 64'd1);
    chk("wd_cycles", 64'(bus.stall_cycles), 64'd14);
    tick();
    bus.cnt_clr     = 1'b1;
    bus.stallreq_id = 1'b1;
    tick();
    bus.cnt_clr     = 1'b0;
    bus.stallreq_id = 1'b0;
    settle();
    chk("clr_timeout", 64'(bus.stall_timeout), 64'd0);
    chk("clr_cycles", 64'(bus.stall_cycles), 64'd0);
    tick();

    // reset while an exception waits on memory
    tick();
    bus.excp_valid = 1'b1;
    bus.excp_pc    = 32'h12345678;
    bus.mem_busy   = 1'b1;
    tick();
    settle();
    chk("rw_state", 64'(bus.ctrl_state), 64'd2);
    tick();
    rst          = 1'b1;
    bus.mem_busy = 1'b0;
    settle();
    chk("rw_in_rst_ack", 64'(bus.excp_ack), 64'd0);
    chk("rw_in_rst_flush", 64'(bus.flush), 64'd0);
    tick();
    rst            = 1'b0;
    bus.excp_valid = 1'b0;
    settle();
    chk("rw_state_after", 64'(bus.ctrl_state), 64'd0);
    chk("rw_stall", 64'(bus.stall), 64'h00);
    chk("rw_flush", 64'(bus.flush), 64'd0);
    chk("rw_ack", 64'(bus.excp_ack), 64'd0);
    chk("rw_new_pc", 64'(bus.new_pc), 64'h0);
    chk("rw_cycles", 64'(bus.stall_cycles), 64'd0);
    chk("rw_timeout", 64'(bus.stall_timeout), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage integer core. It collects stall requests from ID (load-use), EX (multi-cycle ops) and MEM (bus wait), and drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It arbitrates exception flushes against in-flight memory accesses and keeps stall statistics plus a stall watchdog.

Parameters:
MAX_STALL, 255, consecutive stalled cycles before stall_timeout sets (1..2^RUN_W-1)
RUN_W, 8, width of consecutive-stall run counter
CNT_W, 32, width of total stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stallreq_id  in  1  ID requests hold (load-use)
stallreq_ex  in  1  EX requests hold (multi-cycle op)
mem_busy  in  1  MEM access not yet complete
excp_valid  in  1  exception pending; held high by source until excp_ack
excp_pc  in  32  handler address, stable while excp_valid
cnt_clr  in  1  clears stall_cycles, stall_run, stall_timeout
stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect address, valid when flush=1
excp_ack  out  1  one-cycle accept pulse, coincident with flush
stall_cycles  out  CNT_W  saturating count of cycles with stall!=0
stall_timeout  out  1  sticky watchdog flag
ctrl_state  out  2  debug: 0 RUN, 1 HOLD, 2 EXCP_WAIT, 3 RECOVER

Behaviour:
- Reset: state RUN; stall=0, flush=0, new_pc=0, excp_ack=0, stall_cycles=0, stall_run=0, stall_timeout=0.
- stall/flush/new_pc/excp_ack are combinational from current state and inputs (same-cycle effect); counters and state are registered.
- Stall encoding, priority mem > ex > id: mem_busy -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000. A downstream register whose bit is 0 while the next-upstream bit is 1 loads a bubble.
- RUN/HOLD: state = HOLD when any stall request is active, else RUN. Unstalled cycles advance normally.
- Exception, mem_busy=0, state RUN or HOLD: flush=1, new_pc=excp_pc, excp_ack=1, stall=0 in the same cycle. Exception overrides stallreq_id and stallreq_ex. Next state is RECOVER.
- Exception with mem_busy=1: no flush. Next state is EXCP_WAIT, and stall=6'b011111 is held.
- EXCP_WAIT: stall=6'b011111 while mem_busy=1. In the first cycle with mem_busy=0, flush/ack/new_pc fire as above, then go to RECOVER. If excp_valid drops early (protocol violation), return to RUN with no flush.
- RECOVER: lasts one cycle. stall=0, flush=0, excp_valid ignored so a still-high request cannot double-fire. Then go to RUN (or HOLD if requests are active).
- stall_cycles: +1 each cycle with stall!=0. Saturates at all-ones.
- stall_run: +1 each cycle with stall!=0, cleared on any cycle with stall=0 or flush=1.
- stall_timeout: set when stall_run reaches MAX_STALL. Sticky until rst or cnt_clr.
- cnt_clr: clears all three counters/flags next edge. cnt_clr has priority over increment in the same cycle.
- Reset mid-EXCP_WAIT: pending exception is dropped with no ack; source must re-present it.

Test Plan:
- Reset, then stallreq_id=1 for 2 cycles -> stall=6'b000111 for exactly those 2 cycles; stall_cycles=2; ctrl_state 1 then 0.
- stallreq_id=1, stallreq_ex=1, mem_busy=1 together -> stall=6'b011111. Drop mem_busy -> 6'b001111. Drop ex -> 6'b000111.
- excp_valid=1, excp_pc=32'hBFC00380, mem_busy=0, stallreq_ex=1 -> same cycle flush=1, excp_ack=1, new_pc=32'hBFC00380, stall=0. Next cycle RECOVER, no second ack although excp_valid is still high.
- excp_valid=1 while mem_busy=1 for 3 cycles -> stall=6'b011111 for 3 cycles, no flush. Flush+ack in the first cycle with mem_busy=0.
- MAX_STALL=4, stallreq_ex held 6 cycles -> stall_timeout rises after the 4th stalled cycle and stays after release. cnt_clr pulse -> timeout=0, stall_cycles=0.
- rst asserted during EXCP_WAIT -> all outputs are at reset values next cycle, excp_ack never pulses.
